// File: rtl/axis_to_bram_mc.sv
// AXI-Stream to multi-bank BRAM frame writer: one frame of cfg_len words written from cfg_base into a selected bank.
// Optional tlast protocol checking is enabled with the AXIS_TO_BRAM_TLAST_CHECK_EN macro.
module axis_to_bram_mc #(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  ADDR_WIDTH = 10,
  parameter int unsigned  NUM_BANKS  = 2,
  localparam int unsigned BSW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned LW         = ADDR_WIDTH + 1,
  localparam int unsigned BPW        = DATA_WIDTH / 8,
  localparam int unsigned WEW        = NUM_BANKS * BPW
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic [BSW-1:0]        cfg_bank,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LW-1:0]         cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic [LW-1:0]         words_written,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [NUM_BANKS-1:0]  bram_en,
  output logic [WEW-1:0]        bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
  ,
  output logic                  err_tlast
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [BSW-1:0]          bank_q, bank_d;
  logic [LW-1:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic                    tready_q, tready_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_BANKS-1:0]    en_q, en_d;
  logic [WEW-1:0]          we_q, we_d;
  logic [ADDR_WIDTH-1:0]   baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BSW-1:0]          cfg_bank_clamped;
  logic                    accept;
  logic                    len_reached;
  logic                    final_beat;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
  logic                    err_q, err_d;
`else
  logic                    unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  // Out-of-range bank requests fall onto the highest bank
  always_comb begin
    cfg_bank_clamped = cfg_bank;
    if (32'(cfg_bank) >= NUM_BANKS) cfg_bank_clamped = BSW'(NUM_BANKS - 1);
  end

  assign accept      = (state_q == S_RUN) && s_axis_tvalid && tready_q;
  assign len_reached = (LW'(cnt_q + LW'(1)) == len_q);
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
  assign final_beat  = len_reached || s_axis_tlast;
`else
  assign final_beat  = len_reached;
`endif

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    len_d    = len_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    tready_d = 1'b0;
    en_d     = '0;
    we_d     = '0;
    baddr_d  = baddr_q;
    wdata_d  = wdata_q;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
    err_d    = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          bank_d = cfg_bank_clamped;
          addr_d = cfg_base;
          len_d  = cfg_len;
          cnt_d  = '0;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
          err_d  = 1'b0;
`endif
          if (cfg_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            tready_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        tready_d = 1'b1;
        if (accept) begin
          cnt_d   = LW'(cnt_q + LW'(1));
          addr_d  = ADDR_WIDTH'(addr_q + ADDR_WIDTH'(1));
          baddr_d = addr_q;
          wdata_d = s_axis_tdata;
          for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (32'(bank_q) == b) begin
              en_d[b]             = 1'b1;
              we_d[b*BPW +: BPW]  = '1;
            end
          end
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
          if (s_axis_tlast != len_reached) err_d = 1'b1;
`endif
          if (final_beat) begin
            state_d  = S_DONE;
            tready_d = 1'b0;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      bank_q   <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= '0;
      we_q     <= '0;
      baddr_q  <= '0;
      wdata_q  <= '0;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      wdata_q  <= wdata_d;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = cnt_q;
  assign s_axis_tready = tready_q;
  assign bram_en       = en_q;
  assign bram_we       = we_q;
  assign bram_addr     = baddr_q;
  assign bram_wdata    = wdata_q;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
  assign err_tlast     = err_q;
`endif

endmodule

// File: tb/tb_axis_to_bram_mc.sv
// Bench for axis_to_bram_mc: frame table plus reset / tlast sequences, with a write scoreboard.
module tb_axis_to_bram_mc;

  logic        ACLK;
  logic        ARESET;
  logic        cfg_start;
  logic [0:0]  cfg_bank;
  logic [9:0]  cfg_base;
  logic [10:0] cfg_len;
  logic        busy;
  logic        done;
  logic [10:0] words_written;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [1:0]  bram_en;
  logic [7:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
  logic        err_tlast;
`endif

  axis_to_bram_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_BANKS(2)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_bank      (cfg_bank),
    .cfg_base      (cfg_base),
    .cfg_len       (cfg_len),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata)
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
    ,
    .err_tlast     (err_tlast)
`endif
  );

  typedef struct {
    logic [0:0]  bank;
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [0:0]  bank;
    logic [9:0]  base;
    logic [10:0] len;
    logic [31:0] dseed;
    bit          toggle;
    bit          mid;
    logic [0:0]  exp_bank;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every BRAM write must match the oldest expected write
  always @(negedge ACLK) begin
    if (!ARESET && bram_en != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=en %0h addr %0h required=no write", bram_en, bram_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_en",   64'(bram_en),    (mon_e.bank == 1'b1) ? 64'h2 : 64'h1);
        chk("wr_we",   64'(bram_we),    (mon_e.bank == 1'b1) ? 64'hF0 : 64'h0F);
        chk("wr_addr", 64'(bram_addr),  64'(mon_e.addr));
        chk("wr_data", 64'(bram_wdata), 64'(mon_e.data));
      end
    end
  end

  task automatic run_frame(input logic [0:0] bank, input logic [9:0] base, input logic [10:0] len,
                           input logic [31:0] dseed, input bit toggle, input bit mid,
                           input logic [0:0] exp_bank, input int last_at);
    int n_exp;
    int k;
    int cyc;
    n_exp = int'(len);
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
    if (last_at + 1 < n_exp) n_exp = last_at + 1;
`endif
    @(negedge ACLK);
    cfg_bank  = bank;
    cfg_base  = base;
    cfg_len   = len;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < n_exp && cyc < 4000) begin
      cfg_start = mid && (cyc == 1);
      if (mid) begin
        cfg_bank = ~bank;
        cfg_len  = 11'd2;
        cfg_base = 10'(base + 10'h80);
      end
      s_axis_tvalid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_axis_tdata  = dseed + 32'(k);
      s_axis_tlast  = (k == last_at);
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back('{exp_bank, 10'(base + 10'(k)), dseed + 32'(k)});
        k++;
      end
      @(negedge ACLK);
      cyc++;
    end
    cfg_start     = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (k < n_exp) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=%0d beats required=%0d", k, n_exp);
    end
    chk("done_at_end",   64'(done),          64'd1);
    chk("busy_at_end",   64'(busy),          64'd1);
    chk("tready_dropped",64'(s_axis_tready), 64'd0);
    chk("words_written", 64'(words_written), 64'(n_exp));
    @(negedge ACLK);
    chk("done_pulse",    64'(done),          64'd0);
    chk("busy_fall",     64'(busy),          64'd0);
    chk("writes_drained",64'(exp_q.size()),  64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   64'(busy),          64'd0);
    chk({tag, "_done"},   64'(done),          64'd0);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_en"},     64'(bram_en),       64'd0);
    chk({tag, "_we"},     64'(bram_we),       64'd0);
    chk({tag, "_addr"},   64'(bram_addr),     64'd0);
    chk({tag, "_wdata"},  64'(bram_wdata),    64'd0);
    chk({tag, "_ww"},     64'(words_written), 64'd0);
`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
    chk({tag, "_err"},    64'(err_tlast),     64'd0);
`endif
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{1'b1, 10'h3FE, 11'd4,    32'hA0,   1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 10'h010, 11'd3,    32'hB0,   1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 10'h055, 11'd0,    32'hC0,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 10'h200, 11'd5,    32'hD0,   1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 10'h3FF, 11'd1,    32'hE0,   1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 10'h123, 11'd1024, 32'h1000, 1'b0, 1'b0, 1'b1};

    ARESET        = 1'b1;
    cfg_start     = 1'b0;
    cfg_bank      = 1'b0;
    cfg_base      = 10'h0;
    cfg_len       = 11'd0;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_all_zero("reset");
    ARESET = 1'b0;
    @(negedge ACLK);

    foreach (vecs[i])
      run_frame(vecs[i].bank, vecs[i].base, vecs[i].len, vecs[i].dseed, vecs[i].toggle,
                vecs[i].mid, vecs[i].exp_bank, int'(vecs[i].len) - 1);

    // Reset in the middle of a frame drops the in-flight write
    @(negedge ACLK);
    cfg_bank  = 1'b1;
    cfg_base  = 10'h040;
    cfg_len   = 11'd5;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h400 + 32'(k);
      if (s_axis_tready) begin
        exp_q.push_back('{1'b1, 10'(10'h040 + 10'(k)), 32'h400 + 32'(k)});
        k++;
      end
      if (k < 2) @(negedge ACLK);
    end
    chk("rst_two_beats", 64'(k), 64'd2);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    @(negedge ACLK);
    ARESET = 1'b0;
    run_frame(1'b0, 10'h077, 11'd1, 32'h600, 1'b0, 1'b0, 1'b0, 0);

`ifdef AXIS_TO_BRAM_TLAST_CHECK_EN
    run_frame(1'b0, 10'h020, 11'd8, 32'h500, 1'b0, 1'b0, 1'b0, 2);
    chk("err_early_tlast", 64'(err_tlast), 64'd1);
    @(negedge ACLK);
    cfg_bank  = 1'b1;
    cfg_base  = 10'h030;
    cfg_len   = 11'd2;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    chk("err_cleared", 64'(err_tlast), 64'd0);
    for (int j = 0; j < 2; j++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h700 + 32'(j);
      s_axis_tlast  = (j == 1);
      exp_q.push_back('{1'b1, 10'(10'h030 + 10'(j)), 32'h700 + 32'(j)});
      @(negedge ACLK);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("err_done", 64'(done), 64'd1);
    @(negedge ACLK);
    chk("err_clean_frame", 64'(err_tlast), 64'd0);
    chk("err_drained", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
